// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/mret sequencer.
// Holds the CSR addresses, mstatus bit positions, default cause codes, the
// sequencer state enumeration and the mstatus rewrite helpers.
package trap_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  // CSR map
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h000;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h005;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h041;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h042;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h044;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // Default mcause codes and redirect alignment mask
  localparam logic [XLEN-1:0] DEF_CAUSE_ILLEGAL = 32'd2;
  localparam logic [XLEN-1:0] DEF_CAUSE_EBREAK  = 32'd3;
  localparam logic [XLEN-1:0] DEF_CAUSE_ECALL   = 32'd11;
  localparam logic [XLEN-1:0] DEF_MTVEC_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_STRD,
    ST_T_STWR,
    ST_T_VEC,
    ST_R_STRD,
    ST_R_STWR,
    ST_R_EPC,
    ST_REDIR
  } state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, keep everything else.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] old);
    logic [XLEN-1:0] r;
    r               = old;
    r[MSTATUS_MPIE] = old[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, keep everything else.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] old);
    logic [XLEN-1:0] r;
    r               = old;
    r[MSTATUS_MIE]  = old[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer. Owns the single CSR register-file port: passes the
// instruction CSR path through while idle, and otherwise steps through the
// mepc/mcause/mstatus/mtvec (trap) or mstatus/mepc (mret) accesses before
// issuing a one-cycle PC redirect.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   illegal, ebreak, ecall, mret  one-cycle decode request pulses
//   trap_pc                       PC of the requesting instruction
//   ins_csr_w/addr/wdata          instruction CSR write path (idle only)
//   csr_w/addr/wdata, csr_rdata   CSR register-file port (comb read)
//   stall                         freeze fetch/decode
//   pc_load, pc_target            redirect strobe and aligned target
//   busy                          sequencer not idle
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] MTVEC_MASK    = DEF_MTVEC_MASK,
  parameter logic [XLEN-1:0] CAUSE_ILLEGAL = DEF_CAUSE_ILLEGAL,
  parameter logic [XLEN-1:0] CAUSE_EBREAK  = DEF_CAUSE_EBREAK,
  parameter logic [XLEN-1:0] CAUSE_ECALL   = DEF_CAUSE_ECALL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              illegal,
  input  logic              ebreak,
  input  logic              ecall,
  input  logic              mret,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              ins_csr_w,
  input  logic [CSR_AW-1:0] ins_csr_addr,
  input  logic [XLEN-1:0]   ins_csr_wdata,
  output logic              csr_w,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              stall,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_target,
  output logic              busy
);

  state_e          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] cap_q;

  logic            trap_req;
  logic            accept;
  logic [XLEN-1:0] cause_sel;

  // Request priority: illegal > ebreak > ecall > mret; only taken while idle.
  always_comb begin
    trap_req  = illegal | ebreak | ecall;
    cause_sel = CAUSE_ECALL;
    if (illegal)     cause_sel = CAUSE_ILLEGAL;
    else if (ebreak) cause_sel = CAUSE_EBREAK;
    accept    = (state == ST_IDLE) && (trap_req || mret);
  end

  // Sequencer state, latched request data and registered redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      cap_q     <= '0;
      pc_target <= '0;
      pc_load   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= cause_sel;
            busy    <= 1'b1;
            state   <= ST_T_EPC;
          end else if (mret) begin
            busy    <= 1'b1;
            state   <= ST_R_STRD;
          end
        end
        ST_T_EPC:   state <= ST_T_CAUSE;
        ST_T_CAUSE: state <= ST_T_STRD;
        ST_T_STRD: begin
          cap_q <= csr_rdata;
          state <= ST_T_STWR;
        end
        ST_T_STWR:  state <= ST_T_VEC;
        ST_T_VEC: begin
          cap_q     <= csr_rdata;
          pc_target <= csr_rdata & MTVEC_MASK;
          pc_load   <= 1'b1;
          state     <= ST_REDIR;
        end
        ST_R_STRD: begin
          cap_q <= csr_rdata;
          state <= ST_R_STWR;
        end
        ST_R_STWR:  state <= ST_R_EPC;
        ST_R_EPC: begin
          cap_q     <= csr_rdata;
          pc_target <= csr_rdata & MTVEC_MASK;
          pc_load   <= 1'b1;
          state     <= ST_REDIR;
        end
        ST_REDIR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // CSR port steering and stall. The idle pass-through is combinational, so
  // the accept cycle can suppress a coincident instruction CSR write.
  always_comb begin
    csr_w     = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    stall     = 1'b1;
    case (state)
      ST_IDLE: begin
        csr_w     = ins_csr_w & ~accept;
        csr_addr  = ins_csr_addr;
        csr_wdata = ins_csr_wdata;
        stall     = accept;
      end
      ST_T_EPC: begin
        csr_w     = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
      end
      ST_T_CAUSE: begin
        csr_w     = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      ST_T_STRD: csr_addr = CSR_MSTATUS;
      ST_T_STWR: begin
        csr_w     = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(cap_q);
      end
      ST_T_VEC:  csr_addr = CSR_MTVEC;
      ST_R_STRD: csr_addr = CSR_MSTATUS;
      ST_R_STWR: begin
        csr_w     = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(cap_q);
      end
      ST_R_EPC:  csr_addr = CSR_MEPC;
      default:   ;
    endcase
    // Reset silences the port and stall even through the idle pass-through.
    if (!rst_n) begin
      csr_w = 1'b0;
      stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a behavioural CSR register file.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              illegal, ebreak, ecall, mret;
  logic [31:0]       trap_pc;
  logic              ins_csr_w;
  logic [11:0]       ins_csr_addr;
  logic [31:0]       ins_csr_wdata;
  logic              csr_w;
  logic [11:0]       csr_addr;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              stall, pc_load, busy;
  logic [31:0]       pc_target;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] csr_mem [0:4095];

  always #5 clk = ~clk;

  // CSR register file: combinational read, write on rising edge.
  always_ff @(posedge clk) if (csr_w) csr_mem[csr_addr] <= csr_wdata;
  assign csr_rdata = csr_mem[csr_addr];

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .illegal(illegal), .ebreak(ebreak), .ecall(ecall), .mret(mret),
    .trap_pc(trap_pc),
    .ins_csr_w(ins_csr_w), .ins_csr_addr(ins_csr_addr), .ins_csr_wdata(ins_csr_wdata),
    .csr_w(csr_w), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target), .busy(busy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    ins_csr_w = 1'b1; ins_csr_addr = a; ins_csr_wdata = d;
    step();
    ins_csr_w = 1'b0;
  endtask

  // Runs from the accept cycle until pc_load; cyc=0 means it never came.
  task automatic wait_pc_load(input int inj_at, output int cyc, output logic stall_ok);
    cyc = 0; stall_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      illegal = 1'b0; ebreak = 1'b0; ecall = 1'b0; mret = 1'b0;
      if (i == inj_at) ecall = 1'b1;
      #1;
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (pc_load === 1'b1) begin cyc = i; break; end
    end
    ecall = 1'b0;
  endtask

  task automatic test_reset();
    ins_csr_w = 1'b1; ins_csr_addr = CSR_MIP; ins_csr_wdata = 32'h1;
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rst_pc_load: got %b want 0", pc_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (pc_target !== 32'h0) begin n_fail++; $display("FAIL rst_pc_target: got %h want 0", pc_target); end
    n_checks++; if (csr_w !== 1'b0) begin n_fail++; $display("FAIL rst_csr_w: got %b want 0", csr_w); end
    ins_csr_w = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ecall();
    int cyc; logic ok;
    csr_write(CSR_MTVEC, 32'h203);
    csr_write(CSR_MSTATUS, 32'h8);
    csr_write(CSR_MEPC, 32'h0);
    csr_write(CSR_MCAUSE, 32'h0);
    csr_write(CSR_MIP, 32'h0);
    trap_pc = 32'h100; ecall = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ecall_accept_stall: got %b want 1", stall); end
    wait_pc_load(0, cyc, ok);
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL ecall_latency: got %0d want 6", cyc); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ecall_stall_cont: got %b want 1", ok); end
    n_checks++; if (pc_target !== 32'h200) begin n_fail++; $display("FAIL ecall_target: got %h want 00000200", pc_target); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ecall_redir_busy: got %b want 1", busy); end
    n_checks++; if (csr_mem[CSR_MEPC] !== 32'h100) begin n_fail++; $display("FAIL ecall_mepc: got %h want 00000100", csr_mem[CSR_MEPC]); end
    n_checks++; if (csr_mem[CSR_MCAUSE] !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h want 0000000b", csr_mem[CSR_MCAUSE]); end
    n_checks++; if (csr_mem[CSR_MSTATUS] !== 32'h80) begin n_fail++; $display("FAIL ecall_mstatus: got %h want 00000080", csr_mem[CSR_MSTATUS]); end
    step();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL ecall_pulse_width: got %b want 0", pc_load); end
    n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ecall_idle: got stall=%b busy=%b want 0/0", stall, busy); end
    n_checks++; if (pc_target !== 32'h200) begin n_fail++; $display("FAIL ecall_target_hold: got %h want 00000200", pc_target); end
  endtask

  task automatic test_mret();
    int cyc; logic ok;
    csr_write(CSR_MEPC, 32'h104);
    mret = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mret_accept_stall: got %b want 1", stall); end
    wait_pc_load(0, cyc, ok);
    n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL mret_latency: got %0d want 4", cyc); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mret_stall_cont: got %b want 1", ok); end
    n_checks++; if (pc_target !== 32'h104) begin n_fail++; $display("FAIL mret_target: got %h want 00000104", pc_target); end
    n_checks++; if (csr_mem[CSR_MSTATUS] !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h want 00000088", csr_mem[CSR_MSTATUS]); end
    step();
  endtask

  task automatic test_priority();
    int cyc; logic ok; int extra;
    trap_pc = 32'h300; illegal = 1'b1; ecall = 1'b1; mret = 1'b1;
    ins_csr_w = 1'b1; ins_csr_addr = CSR_MIP; ins_csr_wdata = 32'hDEAD;
    #1;
    n_checks++; if (csr_w !== 1'b0) begin n_fail++; $display("FAIL prio_csr_w_suppr: got %b want 0", csr_w); end
    wait_pc_load(2, cyc, ok);
    ins_csr_w = 1'b0;
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL prio_latency: got %0d want 6", cyc); end
    n_checks++; if (csr_mem[CSR_MCAUSE] !== 32'd2) begin n_fail++; $display("FAIL prio_mcause: got %h want 00000002", csr_mem[CSR_MCAUSE]); end
    n_checks++; if (csr_mem[CSR_MEPC] !== 32'h300) begin n_fail++; $display("FAIL prio_mepc: got %h want 00000300", csr_mem[CSR_MEPC]); end
    n_checks++; if (csr_mem[CSR_MSTATUS] !== 32'h80) begin n_fail++; $display("FAIL prio_mstatus: got %h want 00000080", csr_mem[CSR_MSTATUS]); end
    n_checks++; if (csr_mem[CSR_MIP] !== 32'h0) begin n_fail++; $display("FAIL prio_mip_untouched: got %h want 00000000", csr_mem[CSR_MIP]); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pc_load === 1'b1) extra++;
    end
    n_checks++; if (extra != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_single_redirect: got extra=%0d busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_passthru();
    int cyc; logic ok;
    ins_csr_w = 1'b1; ins_csr_addr = CSR_MTVEC; ins_csr_wdata = 32'h400; #1;
    n_checks++; if (csr_w !== 1'b1 || csr_addr !== CSR_MTVEC || csr_wdata !== 32'h400) begin
      n_fail++; $display("FAIL pass_port: got w=%b a=%h d=%h want 1/005/00000400", csr_w, csr_addr, csr_wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %b want 0", stall); end
    step();
    ins_csr_w = 1'b0;
    n_checks++; if (csr_mem[CSR_MTVEC] !== 32'h400) begin n_fail++; $display("FAIL pass_written: got %h want 00000400", csr_mem[CSR_MTVEC]); end
    ins_csr_w = 1'b1; ins_csr_wdata = 32'h800; ebreak = 1'b1; trap_pc = 32'h500; #1;
    n_checks++; if (csr_w !== 1'b0) begin n_fail++; $display("FAIL coinc_csr_w: got %b want 0", csr_w); end
    wait_pc_load(0, cyc, ok);
    ins_csr_w = 1'b0;
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL coinc_latency: got %0d want 6", cyc); end
    n_checks++; if (csr_mem[CSR_MTVEC] !== 32'h400) begin n_fail++; $display("FAIL coinc_mtvec: got %h want 00000400", csr_mem[CSR_MTVEC]); end
    n_checks++; if (csr_mem[CSR_MCAUSE] !== 32'd3) begin n_fail++; $display("FAIL coinc_mcause: got %h want 00000003", csr_mem[CSR_MCAUSE]); end
    n_checks++; if (csr_mem[CSR_MSTATUS] !== 32'h0) begin n_fail++; $display("FAIL coinc_mstatus: got %h want 00000000", csr_mem[CSR_MSTATUS]); end
    n_checks++; if (pc_target !== 32'h400) begin n_fail++; $display("FAIL coinc_target: got %h want 00000400", pc_target); end
    step();
  endtask

  task automatic test_reset_mid();
    csr_write(CSR_MSTATUS, 32'h8);
    csr_write(CSR_MEPC, 32'h0);
    csr_write(CSR_MCAUSE, 32'h0);
    trap_pc = 32'h600; ecall = 1'b1;
    step(); ecall = 1'b0;
    step(); step(); #1;
    n_checks++; if (csr_w !== 1'b0 || csr_addr !== CSR_MSTATUS) begin
      n_fail++; $display("FAIL mid_in_strd: got w=%b a=%h want 0/000", csr_w, csr_addr); end
    rst_n = 1'b0; #1;
    n_checks++; if (stall !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0 || csr_w !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outs: got stall=%b busy=%b pc_load=%b csr_w=%b want 0", stall, busy, pc_load, csr_w); end
    step(); step();
    n_checks++; if (pc_load !== 1'b0 || pc_target !== 32'h0) begin n_fail++; $display("FAIL mid_no_redirect: got %b/%h want 0/0", pc_load, pc_target); end
    n_checks++; if (csr_mem[CSR_MEPC] !== 32'h600 || csr_mem[CSR_MCAUSE] !== 32'd11) begin
      n_fail++; $display("FAIL mid_partial_writes: got mepc=%h mcause=%h want 600/b", csr_mem[CSR_MEPC], csr_mem[CSR_MCAUSE]); end
    n_checks++; if (csr_mem[CSR_MSTATUS] !== 32'h8) begin n_fail++; $display("FAIL mid_mstatus_kept: got %h want 00000008", csr_mem[CSR_MSTATUS]); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic ok;
    // Request raised together with reset release: taken on the first edge.
    rst_n = 1'b1; ebreak = 1'b1; trap_pc = 32'h700; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL first_accept_stall: got %b want 1", stall); end
    wait_pc_load(0, cyc, ok);
    n_checks++; if (cyc != 6 || ok !== 1'b1) begin n_fail++; $display("FAIL first_seq: got cyc=%0d stall_ok=%b want 6/1", cyc, ok); end
    n_checks++; if (csr_mem[CSR_MEPC] !== 32'h700 || csr_mem[CSR_MSTATUS] !== 32'h80) begin
      n_fail++; $display("FAIL first_csrs: got mepc=%h mstatus=%h want 700/80", csr_mem[CSR_MEPC], csr_mem[CSR_MSTATUS]); end
    step();
    ebreak = 1'b1; trap_pc = 32'h704; #1;
    n_checks++; if (busy !== 1'b0 || pc_load !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b pc_load=%b want 0/0", busy, pc_load); end
    wait_pc_load(0, cyc, ok);
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL b2b_latency: got %0d want 6", cyc); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_cont: got %b want 1", ok); end
    n_checks++; if (pc_target !== 32'h400) begin n_fail++; $display("FAIL b2b_target: got %h want 00000400", pc_target); end
    n_checks++; if (csr_mem[CSR_MEPC] !== 32'h704 || csr_mem[CSR_MSTATUS] !== 32'h0 || csr_mem[CSR_MCAUSE] !== 32'd3) begin
      n_fail++; $display("FAIL b2b_csrs: got mepc=%h mstatus=%h mcause=%h want 704/0/3", csr_mem[CSR_MEPC], csr_mem[CSR_MSTATUS], csr_mem[CSR_MCAUSE]); end
    step();
    n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle: got stall=%b busy=%b want 0/0", stall, busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    illegal = 1'b0; ebreak = 1'b0; ecall = 1'b0; mret = 1'b0;
    trap_pc = '0; ins_csr_w = 1'b0; ins_csr_addr = '0; ins_csr_wdata = '0;
    test_reset();
    test_ecall();
    test_mret();
    test_priority();
    test_passthru();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
